// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/advance decisions for a five-stage
// pipeline, a RUN/DWAIT/HALT state machine and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dreq,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic             halt_wb,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DWAIT = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             wait_now;
    logic             active;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Hazard detection; in DWAIT only dhit matters, the request is already in flight.
    always_comb begin
        active   = (state_q == RUN) || (state_q == DWAIT);
        load_use = idex_memread && (idex_rd != 5'd0) &&
                   ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));
        wait_now = (state_q == DWAIT) ? !dhit : (exmem_dreq && !dhit);
    end

    // State register with synchronous reset back to RUN.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Next-state: halt retirement wins, then data wait; HALT only leaves on reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (halt_wb)       state_d = HALT;
                else if (wait_now) state_d = DWAIT;
            end
            DWAIT: begin
                if (halt_wb)       state_d = HALT;
                else if (!wait_now) state_d = RUN;
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // Output decode in priority order: halt, wait, branch, load-use, jump, fetch, normal.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (RST) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (active) begin
            if (halt_wb) begin
                pc_en = 1'b1; ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1; memwb_en = 1'b1;
            end else if (wait_now) begin
                pc_en = 1'b0;
            end else if (branch_taken) begin
                pc_en = 1'b1; ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1; memwb_en = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID one cycle; the load drains from ID/EX behind a bubble.
                idex_en = 1'b1; exmem_en = 1'b1; memwb_en = 1'b1;
                idex_flush = 1'b1;
            end else if (jump_id) begin
                pc_en = 1'b1; ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1; memwb_en = 1'b1;
                ifid_flush = 1'b1;
            end else if (!ihit) begin
                ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1; memwb_en = 1'b1;
                ifid_flush = 1'b1;
            end else begin
                pc_en = 1'b1; ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1; memwb_en = 1'b1;
            end
        end
    end

    // Counter next values: clear beats increment, nothing counts outside RUN/DWAIT.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else if (active) begin
            if (!pc_en)                   stall_cnt_d = sat_inc(stall_cnt_q);
            if (ifid_flush || idex_flush) flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    // Counter registers, zeroed by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign halted    = (state_q == HALT) && !RST;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
